// File: rtl/ysyx_25030085_lsu_pkg.sv
// ysyx_25030085_lsu_pkg
//   Shared definitions for the load/store unit:
//   - RV32I load/store funct3 encodings
//   - LSU state encoding
//   - default WAIT timeout
//   - f3_legal(): legality of a funct3 code for a load or a store
package ysyx_25030085_lsu_pkg;

    localparam int LSU_TIMEOUT_DEFAULT = 255;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Unsigned widths exist only for loads; stores accept B/H/W.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !is_store;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_25030085_lsu_align.sv
// ysyx_25030085_lsu_align
//   Purely combinational byte-lane logic for the LSU.
//   Datapath side (driven from the latched request):
//     is_store, funct3, lane, wdata  -> wstrb, wdata_rep
//     rdata (bus word)               -> load_data (lane-selected, extended)
//   Check side (driven from the incoming request):
//     chk_is_store, chk_funct3, chk_lane -> misalign, illegal
module ysyx_25030085_lsu_align
    import ysyx_25030085_lsu_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic        chk_is_store,
    input  logic [2:0]  chk_funct3,
    input  logic [1:0]  chk_lane,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        illegal
);

    logic [31:0] shifted;

    // Move the addressed lane down to bit 0 before extension.
    assign shifted = rdata >> {lane, 3'b000};

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        wstrb     = 4'b0000;
        wdata_rep = wdata;
        load_data = 32'h0;
        case (funct3)
            F3_B: begin
                wstrb     = is_store ? (4'b0001 << lane) : 4'b0000;
                wdata_rep = {4{wdata[7:0]}};
                load_data = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_H: begin
                wstrb     = is_store ? (4'b0011 << lane) : 4'b0000;
                wdata_rep = {2{wdata[15:0]}};
                load_data = {{16{shifted[15]}}, shifted[15:0]};
            end
            F3_W: begin
                wstrb     = is_store ? 4'b1111 : 4'b0000;
                load_data = rdata;
            end
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            default: load_data = 32'h0;
        endcase
    end

    always_comb begin
        misalign = 1'b0;
        case (chk_funct3)
            F3_H, F3_HU: misalign = chk_lane[0];
            F3_W:        misalign = |chk_lane;
            default:     misalign = 1'b0;
        endcase
        illegal = !f3_legal(chk_is_store, chk_funct3);
    end

endmodule

// File: rtl/ysyx_25030085_lsu.sv
// ysyx_25030085_lsu
//   Single-outstanding load/store unit between the core and a simple
//   valid/ready memory bus. FSM: IDLE -> REQ -> WAIT -> RESP -> IDLE, with
//   IDLE -> RESP directly for misaligned / illegal requests, and WAIT -> RESP
//   with an error after TIMEOUT_CYCLES cycles without a bus response.
//   Ports:
//     clk, rst (sync, active-high)
//     core side : req_valid/req_ready, req_is_store, req_funct3, req_addr,
//                 req_wdata, resp_valid, resp_rdata, resp_err
//     bus side  : mem_req_valid/mem_req_ready, mem_we, mem_addr, mem_wdata,
//                 mem_wstrb, mem_resp_valid, mem_rdata
module ysyx_25030085_lsu
    import ysyx_25030085_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e  state;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] cnt_inc;

    logic [3:0]  wstrb;
    logic [31:0] wdata_rep;
    logic [31:0] load_data;
    logic        misalign;
    logic        illegal;

    ysyx_25030085_lsu_align u_align (
        .is_store     (is_store_q),
        .funct3       (funct3_q),
        .lane         (addr_q[1:0]),
        .wdata        (wdata_q),
        .rdata        (mem_rdata),
        .chk_is_store (req_is_store),
        .chk_funct3   (req_funct3),
        .chk_lane     (req_addr[1:0]),
        .wstrb        (wstrb),
        .wdata_rep    (wdata_rep),
        .load_data    (load_data),
        .misalign     (misalign),
        .illegal      (illegal)
    );

    assign cnt_inc = wait_cnt + 1'b1;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state      <= ST_IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    if (req_valid) begin
                        is_store_q <= req_is_store;
                        funct3_q   <= req_funct3;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        // Bad requests never reach the bus.
                        if (misalign || illegal) begin
                            rdata_q <= 32'h0;
                            err_q   <= 1'b1;
                            state   <= ST_RESP;
                        end else begin
                            state   <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    wait_cnt <= '0;
                    if (mem_req_ready) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        rdata_q  <= is_store_q ? 32'h0 : load_data;
                        err_q    <= 1'b0;
                        wait_cnt <= '0;
                        state    <= ST_RESP;
                    end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                        rdata_q  <= 32'h0;
                        err_q    <= 1'b1;
                        wait_cnt <= '0;
                        state    <= ST_RESP;
                    end else begin
                        wait_cnt <= cnt_inc;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // All outputs are decoded from registers only.
    assign req_ready     = (state == ST_IDLE);
    assign resp_valid    = (state == ST_RESP);
    assign resp_rdata    = rdata_q;
    assign resp_err      = err_q;
    assign mem_req_valid = (state == ST_REQ);
    assign mem_we        = is_store_q;
    assign mem_addr      = {addr_q[31:2], 2'b00};
    assign mem_wdata     = wdata_rep;
    assign mem_wstrb     = wstrb;

endmodule

// File: tb/tb_ysyx_25030085_lsu.sv
// tb_ysyx_25030085_lsu
//   Directed and randomized bench for the LSU. Expected responses come from a
//   byte-size/offset reference model; the DUT runs with TIMEOUT_CYCLES=8.
module tb_ysyx_25030085_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    ysyx_25030085_lsu #(.TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_store   (req_is_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; drive and sample 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: access size in bytes, offset in word, extension and lane replication.
    function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] rd,
                                  output bit err, output logic [31:0] rdata,
                                  output logic [3:0] strb, output logic [31:0] mwdata);
        int size;
        int off;
        bit legal;
        logic [31:0] word;
        legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << f3[1:0];
        off   = int'(a % 4);
        err   = !legal || ((a % size) != 0);
        rdata = 32'h0;
        strb  = 4'b0000;
        mwdata = 32'h0;
        if (!err) begin
            if (st) begin
                strb = 4'((1 << size) - 1) << off;
                for (int i = 0; i < 4; i++) mwdata[8*i +: 8] = wd[8*(i % size) +: 8];
            end else begin
                word = rd >> (8 * off);
                if (size == 4) rdata = word;
                else begin
                    rdata = word & ((32'h1 << (8 * size)) - 1);
                    if (!f3[2] && word[8*size-1]) rdata = rdata | ~((32'h1 << (8 * size)) - 1);
                end
            end
        end
    endfunction

    task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int rdy_dly, input int rsp_dly, input bit noise,
                          output logic [31:0] got_rdata, output logic got_err);
        bit e;
        logic [31:0] er, ewd;
        logic [3:0] es;
        model(st, f3, a, wd, rd, e, er, es, ewd);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        step();
        req_valid = 1'b0;
        if (e) begin
            check("err_no_bus", 32'(mem_req_valid), 32'd0);
            check("err_resp_valid", 32'(resp_valid), 32'd1);
        end else begin
            for (int i = 0; i <= rdy_dly; i++) begin
                if (noise) begin
                    // Requests and stray bus responses while busy must be ignored.
                    req_valid = 1'b1; req_is_store = 1'($urandom); req_funct3 = 3'($urandom);
                    req_addr = $urandom; req_wdata = $urandom; mem_resp_valid = 1'b1;
                end
                mem_req_ready = (i == rdy_dly);
                check("mem_req_valid", 32'(mem_req_valid), 32'd1);
                check("mem_addr", mem_addr, {a[31:2], 2'b00});
                check("mem_we", 32'(mem_we), 32'(st));
                check("mem_wstrb", 32'(mem_wstrb), 32'(es));
                if (st) check("mem_wdata", mem_wdata, ewd);
                step();
            end
            mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
            for (int i = 0; i < rsp_dly; i++) begin
                check("wait_no_resp", 32'(resp_valid), 32'd0);
                check("wait_no_bus", 32'(mem_req_valid), 32'd0);
                step();
            end
            mem_resp_valid = 1'b1; mem_rdata = rd;
            step();
            mem_resp_valid = 1'b0; mem_rdata = $urandom;
            check("resp_valid", 32'(resp_valid), 32'd1);
        end
        req_valid = 1'b0;
        check("resp_err", 32'(resp_err), 32'(e));
        check("resp_rdata", resp_rdata, er);
        got_rdata = resp_rdata;
        got_err   = resp_err;
        step();
        check("resp_pulse", 32'(resp_valid), 32'd0);
        check("rdata_hold", resp_rdata, er);
        check("err_hold", 32'(resp_err), 32'(e));
    endtask

    initial begin
        logic [31:0] r;
        logic        er;
        rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_rdata = 32'h0;

        // Reset values.
        step();
        step();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        rst = 1'b0;
        step();

        // Stray bus response in IDLE is ignored.
        mem_resp_valid = 1'b1;
        step();
        mem_resp_valid = 1'b0;
        check("idle_stray_resp", 32'(resp_valid), 32'd0);

        // LB sign-extend, minimum latency.
        access(1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h8000_0000, 0, 0, 1'b0, r, er);
        check("lb_rdata_const", r, 32'hFFFF_FF80);
        check("lb_err_const", 32'(er), 32'd0);
        // LHU zero-extend upper half.
        access(1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'hBEEF_1234, 0, 1, 1'b0, r, er);
        check("lhu_rdata_const", r, 32'h0000_BEEF);
        // SH with mem_req_ready delayed 4 cycles; busy-time noise applied.
        access(1'b1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 32'hFFFF_FFFF, 4, 2, 1'b1, r, er);
        check("sh_rdata_zero", r, 32'h0);
        // Misaligned LW.
        access(1'b0, 3'b010, 32'h8000_0001, 32'h0, 32'h1234_5678, 0, 0, 1'b0, r, er);
        check("lw_mis_err", 32'(er), 32'd1);
        // Illegal funct3 for load and for store.
        access(1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 1'b0, r, er);
        access(1'b1, 3'b100, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 1'b0, r, er);
        // Aligned LW to leave nonzero rdata before the timeout case.
        access(1'b0, 3'b010, 32'h8000_0008, 32'h0, 32'hCAFE_F00D, 1, 0, 1'b0, r, er);

        // Timeout: 8 WAIT cycles without a response.
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0010;
        step();
        req_valid = 1'b0; mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("to_wait_no_resp", 32'(resp_valid), 32'd0);
            step();
        end
        check("to_resp_valid", 32'(resp_valid), 32'd1);
        check("to_resp_err", 32'(resp_err), 32'd1);
        check("to_resp_rdata", resp_rdata, 32'h0);
        step();

        // Reset during WAIT, then a stray response.
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0020;
        step();
        req_valid = 1'b0; mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstw_req_ready", 32'(req_ready), 32'd1);
        mem_resp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
        step();
        mem_resp_valid = 1'b0;
        check("rstw_no_resp", 32'(resp_valid), 32'd0);
        check("rstw_req_ready2", 32'(req_ready), 32'd1);
        step();
        check("rstw_no_resp2", 32'(resp_valid), 32'd0);
        check("rstw_rdata", resp_rdata, 32'h0);

        // Reset during REQ abandons the bus request.
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h8000_0031;
        req_wdata = 32'h0000_0077;
        step();
        req_valid = 1'b0;
        check("rstq_in_req", 32'(mem_req_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstq_no_bus", 32'(mem_req_valid), 32'd0);
        check("rstq_ready", 32'(req_ready), 32'd1);
        step();

        // Randomized accesses against the reference model.
        for (int n = 0; n < 60; n++) begin
            bit          st;
            logic [2:0]  f3;
            logic [31:0] a;
            st = 1'($urandom);
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : (st ? 3'($urandom_range(0, 2))
                 : ((($urandom_range(0, 1)) != 0) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5))));
            a  = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
            access(st, f3, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom), r, er);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
